// File: rtl/corescore_reset_sequencer_pkg.sv
// Shared definitions for the core-array reset sequencer: state encoding
// (decoded by debug/status logic), loss counter sizing and width helper.
`timescale 1ns/1ps
package corescore_reset_sequencer_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT_LOCK = 2'd0,
    S_SETTLE    = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Width of a counter that must hold the larger of two cycle counts
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/corescore_reset_sequencer_if.sv
// Sequencer <-> clock-generator / core-group signal bundle.
// CORESCORE_RSTSEQ_LOSSCNT_EN adds the lock-loss counter signal.
`timescale 1ns/1ps
interface corescore_reset_sequencer_if #(
  parameter int unsigned GROUPS = 4
);
  import corescore_reset_sequencer_pkg::*;

  logic              i_locked;
  logic [GROUPS-1:0] o_rst;
  logic              o_ready;
`ifdef CORESCORE_RSTSEQ_LOSSCNT_EN
  logic [LOSS_CNT_W-1:0] o_loss_cnt;

  modport master (input i_locked, output o_rst, output o_ready, output o_loss_cnt);
  modport slave  (output i_locked, input o_rst, input o_ready, input o_loss_cnt);
`else
  modport master (input i_locked, output o_rst, output o_ready);
  modport slave  (output i_locked, input o_rst, input o_ready);
`endif

endinterface

// File: rtl/corescore_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
`timescale 1ns/1ps
module corescore_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two back-to-back flops, both cleared by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/corescore_reset_sequencer.sv
// Staggered reset release for the SERV core array after PLL lock.
// Synchronizes lock, waits SETTLE_CYCLES, then releases one group every
// STAGGER cycles; any lock loss re-asserts all group resets.
// Optional: CORESCORE_RSTSEQ_LOSSCNT_EN enables the saturating lock-loss counter.
`timescale 1ns/1ps
module corescore_reset_sequencer
  import corescore_reset_sequencer_pkg::*;
#(
  parameter int unsigned GROUPS        = 4,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned STAGGER       = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  corescore_reset_sequencer_if.master       bus
);

  localparam int unsigned CNT_W = cnt_width(SETTLE_CYCLES, STAGGER);
  localparam int unsigned GRP_W = $clog2(GROUPS) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [GRP_W-1:0] GRP_LAST     = GRP_W'(GROUPS - 1);

  logic              locked_s;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [GRP_W-1:0]  grp_inc;
  logic [GROUPS-1:0] rst_q, rst_d;
  logic              ready_q, ready_d;

  corescore_sync2 u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.i_locked),
    .o_q   (locked_s)
  );

  assign grp_inc = grp_q + GRP_W'(1);

  // State, counters and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
      grp_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Next state and next register values; lock loss overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    rst_d   = rst_q;
    ready_d = ready_q;

    if (state_q != S_WAIT_LOCK && !locked_s) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      grp_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          cnt_d   = '0;
          grp_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          if (locked_s) state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            grp_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          // Group 0 still held means this is the first edge spent in RELEASE
          if (rst_q[0]) begin
            rst_d[0] = 1'b0;
            cnt_d    = '0;
            if (grp_q == GRP_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end else if (cnt_q == STAGGER_LAST) begin
            cnt_d = '0;
            grp_d = grp_inc;
            rst_d = rst_q & ~(GROUPS'(1) << grp_inc);
            if (grp_inc == GRP_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_WAIT_LOCK;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rst   = rst_q;
  assign bus.o_ready = ready_q;

`ifdef CORESCORE_RSTSEQ_LOSSCNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;
  logic                  abort_c;

  assign abort_c = (state_q != S_WAIT_LOCK) && !locked_s;

  // Saturating count of lock-loss aborts, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      loss_q <= '0;
    end else if (abort_c && loss_q != LOSS_CNT_MAX) begin
      loss_q <= loss_q + LOSS_CNT_W'(1);
    end
  end

  assign bus.o_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_corescore_reset_sequencer.sv
// Directed bench for corescore_reset_sequencer (GROUPS=4, SETTLE=8, STAGGER=4).
`timescale 1ns/1ps
module tb_corescore_reset_sequencer;

  localparam int GROUPS   = 4;
  localparam int SETTLE   = 8;
  localparam int STAGGER  = 4;
  localparam int REL0     = SETTLE + 3;                    // edge of group 0 release
  localparam int READY_AT = REL0 + (GROUPS - 1) * STAGGER; // edge of last release
  localparam int RUN_LEN  = READY_AT + 5;

  logic i_clk = 1'b0;
  logic i_rst;
  int   errors = 0;
  int   checks = 0;

  corescore_reset_sequencer_if #(.GROUPS(GROUPS)) bus ();

  corescore_reset_sequencer #(
    .GROUPS        (GROUPS),
    .SETTLE_CYCLES (SETTLE),
    .STAGGER       (STAGGER)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.master)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Expected resets idx edges after the first edge that samples lock high
  function automatic logic [GROUPS-1:0] exp_rst(input int idx);
    logic [GROUPS-1:0] r;
    for (int g = 0; g < GROUPS; g++) r[g] = (idx < REL0 + g * STAGGER);
    return r;
  endfunction

  // Raise lock and check every edge of the release sequence; optional narrow
  // glitch after edge glitch_at, optional lock drop after edge drop_at
  task automatic run_sequence(input string tag, input int glitch_at, input int drop_at);
    logic [GROUPS-1:0] er;
    logic              erdy;
    bus.i_locked = 1'b1;
    for (int j = 1; j <= RUN_LEN; j++) begin
      tick();
      er   = exp_rst(j - 1);
      erdy = ((j - 1) >= READY_AT);
      checks++;
      if (bus.o_rst !== er || bus.o_ready !== erdy) begin
        errors++;
        $display("FAIL %s edge %0d: o_rst=%b o_ready=%b, expected o_rst=%b o_ready=%b",
                 tag, j - 1, bus.o_rst, bus.o_ready, er, erdy);
      end
      if (j == glitch_at) begin
        bus.i_locked = 1'b0;
        #2;
        bus.i_locked = 1'b1;
      end
      if (j == drop_at) begin
        bus.i_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          tick();
          er   = (k < 3) ? exp_rst(j - 1 + k) : '1;
          erdy = (k < 3) ? ((j - 1 + k) >= READY_AT) : 1'b0;
          checks++;
          if (bus.o_rst !== er || bus.o_ready !== erdy) begin
            errors++;
            $display("FAIL %s drop+%0d: o_rst=%b o_ready=%b, expected o_rst=%b o_ready=%b",
                     tag, k, bus.o_rst, bus.o_ready, er, erdy);
          end
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_rst !== 4'b1111 || bus.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: o_rst=%b o_ready=%b, expected 1111/0", bus.o_rst, bus.o_ready);
      end
    end
    bus.i_locked = 1'b0;
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_rst !== 4'b1111 || bus.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_lock: o_rst=%b o_ready=%b, expected 1111/0", bus.o_rst, bus.o_ready);
      end
    end
  endtask

  task automatic test_nominal();
    run_sequence("nominal", -1, -1);
  endtask

  task automatic test_loss_run();
    logic [GROUPS-1:0] er;
    logic              erdy;
    bus.i_locked = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      er   = (k < 3) ? 4'b0000 : 4'b1111;
      erdy = (k < 3);
      checks++;
      if (bus.o_rst !== er || bus.o_ready !== erdy) begin
        errors++;
        $display("FAIL loss_run+%0d: o_rst=%b o_ready=%b, expected o_rst=%b o_ready=%b",
                 k, bus.o_rst, bus.o_ready, er, erdy);
      end
    end
    run_sequence("relock", -1, -1);
  endtask

  task automatic test_loss_release();
    bus.i_locked = 1'b0;
    repeat (4) tick();
    run_sequence("mid_release", -1, 17);
    run_sequence("after_release_abort", -1, -1);
  endtask

  task automatic test_glitch();
    bus.i_locked = 1'b0;
    repeat (4) tick();
    bus.i_locked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.o_rst !== 4'b1111) begin
        errors++;
        $display("FAIL glitch_pre: o_rst=%b, expected 1111", bus.o_rst);
      end
    end
    // One full clock low: seen by the synchronizer, sequence restarts
    bus.i_locked = 1'b0;
    tick();
    run_sequence("glitch_captured", -1, -1);
    bus.i_locked = 1'b0;
    repeat (4) tick();
    // Sub-cycle pulse between edges: never sampled, timing unchanged
    run_sequence("glitch_missed", 5, -1);
  endtask

  task automatic test_rst_mid();
    bus.i_locked = 1'b0;
    repeat (4) tick();
    bus.i_locked = 1'b1;
    repeat (20) tick();
    checks++;
    if (bus.o_rst !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_pre: o_rst=%b, expected 1000", bus.o_rst);
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (bus.o_rst !== 4'b1111 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: o_rst=%b o_ready=%b, expected 1111/0", bus.o_rst, bus.o_ready);
    end
    repeat (2) tick();
    checks++;
    if (bus.o_rst !== 4'b1111 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold: o_rst=%b o_ready=%b, expected 1111/0", bus.o_rst, bus.o_ready);
    end
    bus.i_locked = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
  endtask

`ifdef CORESCORE_RSTSEQ_LOSSCNT_EN
  task automatic lose_lock(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_locked = 1'b1;
      repeat (4) tick();
      bus.i_locked = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_loss_cnt();
    bus.i_locked = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    checks++;
    if (bus.o_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL loss_cnt_reset: got %0d, expected 0", bus.o_loss_cnt);
    end
    lose_lock(3);
    checks++;
    if (bus.o_loss_cnt !== 8'd3) begin
      errors++;
      $display("FAIL loss_cnt_3: got %0d, expected 3", bus.o_loss_cnt);
    end
    lose_lock(300);
    checks++;
    if (bus.o_loss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL loss_cnt_sat: got %0d, expected 255", bus.o_loss_cnt);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (bus.o_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL loss_cnt_clear: got %0d, expected 0", bus.o_loss_cnt);
    end
    tick();
    i_rst = 1'b0;
  endtask
`endif

  initial begin
    i_rst        = 1'b1;
    bus.i_locked = 1'b1;
    test_reset();
    test_nominal();
    test_loss_run();
    test_loss_release();
    test_glitch();
    test_rst_mid();
`ifdef CORESCORE_RSTSEQ_LOSSCNT_EN
    test_loss_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
